// File: rtl/register_file.sv
// 16x64 general-purpose register file: two combinational read ports, one synchronous write port.
// Optional macro REGFILE_BYPASS_EN forwards dstWrite to the read ports during a write cycle.
module register_file #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src,
  input  logic [DATA_W-1:0] dstWrite,
  output logic [DATA_W-1:0] dstRead,
  output logic [DATA_W-1:0] srcRead
);

  localparam int DEPTH = 1 << ADDR_W;

  // Flop-based storage: every entry must clear on reset, so no RAM inference here.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_we;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we_decode
      assign w_we[gi] = writeEnable && (dst == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        r_mem[i] <= '0;
      end else if (w_we[i]) begin
        r_mem[i] <= dstWrite;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_bypass;
  assign w_bypass = writeEnable && rst_n;
  assign dstRead  = w_bypass ? dstWrite : r_mem[dst];
  assign srcRead  = (w_bypass && (src == dst)) ? dstWrite : r_mem[src];
`else
  assign dstRead  = r_mem[dst];
  assign srcRead  = r_mem[src];
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference model.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        writeEnable;
  logic [3:0]  dst;
  logic [3:0]  src;
  logic [63:0] dstWrite;
  logic [63:0] dstRead;
  logic [63:0] srcRead;

  register_file #(.DATA_W(64), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .writeEnable (writeEnable),
    .dst         (dst),
    .src         (src),
    .dstWrite    (dstWrite),
    .dstRead     (dstRead),
    .srcRead     (srcRead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] model_mem [16];
  logic [63:0] pattern [16];
  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check pre-edge reads, take the edge, update the model.
  task automatic drive_cycle(input logic rn, input logic we, input logic [3:0] d,
                             input logic [3:0] s, input logic [63:0] data,
                             input bit chk, input string tag);
    logic [63:0] exp_d;
    logic [63:0] exp_s;
    rst_n = rn; writeEnable = we; dst = d; src = s; dstWrite = data;
    #1;
    exp_d = model_mem[d];
    exp_s = model_mem[s];
`ifdef REGFILE_BYPASS_EN
    if (rn && we) begin
      exp_d = data;
      if (s == d) exp_s = data;
    end
`endif
    n_txn++;
    $display("txn %0d %s: rst_n=%0b we=%0b dst=%0d src=%0d wdata=%h dstRead=%h srcRead=%h",
             n_txn, tag, rn, we, d, s, data, dstRead, srcRead);
    if (chk) begin
      check_val({tag, ".dstRead"}, dstRead, exp_d);
      check_val({tag, ".srcRead"}, srcRead, exp_s);
    end
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
    end else if (we) begin
      model_mem[d] = data;
    end
    @(negedge clk);
  endtask

  // Address-only probe with writes disabled; no edge between address change and check.
  task automatic peek(input logic [3:0] d, input logic [3:0] s, input string tag);
    rst_n = 1'b1; writeEnable = 1'b0; dst = d; src = s;
    #1;
    check_val({tag, ".dstRead"}, dstRead, model_mem[d]);
    check_val({tag, ".srcRead"}, srcRead, model_mem[s]);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    rst_n = 1'b0; writeEnable = 1'b0; dst = '0; src = '0; dstWrite = '0;

    // Reset with a competing write; outputs undefined before this edge.
    drive_cycle(1'b0, 1'b1, 4'd2, 4'd2, 64'hDEAD, 1'b0, "init_reset");
    for (int a = 0; a < 16; a++) begin
      peek(4'(a), 4'(15 - a), "reset_sweep");
    end

    pattern[0] = 64'h1C8F_BCBF_B54D_70F0;
    for (int n = 1; n < 16; n++) pattern[n] = {$urandom, $urandom};
    for (int n = 0; n < 16; n++) begin
      drive_cycle(1'b1, 1'b1, 4'(n), 4'((n + 1) % 16), pattern[n], 1'b1, "wr_sweep");
      drive_cycle(1'b1, 1'b0, 4'(n), 4'(n), 64'h0, 1'b1, "rd_sweep");
      check_val("pattern", dstRead, pattern[n]);
    end

    drive_cycle(1'b1, 1'b0, 4'd3, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "wr_disabled");
    peek(4'd3, 4'd3, "wr_disabled_after");
    check_val("entry3_kept", dstRead, pattern[3]);

    drive_cycle(1'b1, 1'b1, 4'd5, 4'd0, 64'hA5A5, 1'b1, "wr5");
    drive_cycle(1'b1, 1'b1, 4'd10, 4'd0, 64'h5A5A, 1'b1, "wr10");
    peek(4'd5, 4'd10, "indep");
    check_val("indep_dst", dstRead, 64'hA5A5);
    check_val("indep_src", srcRead, 64'h5A5A);
    peek(4'd10, 4'd5, "indep_swap");

    drive_cycle(1'b1, 1'b1, 4'd7, 4'd0, 64'h1, 1'b1, "wr7_old");
    drive_cycle(1'b1, 1'b1, 4'd7, 4'd7, 64'h2, 1'b1, "same_cycle");
    peek(4'd7, 4'd7, "same_cycle_after");
    check_val("same_cycle_new", srcRead, 64'h2);

    drive_cycle(1'b0, 1'b1, 4'd2, 4'd2, 64'hDEAD, 1'b1, "reset_prio");
    peek(4'd2, 4'd7, "reset_prio_after");
    check_val("entry2_zero", dstRead, 64'h0);

    for (int t = 0; t < 250; t++) begin
      logic       rn;
      logic       we;
      logic [3:0] d;
      logic [3:0] s;
      rn = ($urandom_range(0, 15) != 0);
      we = $urandom_range(0, 1) != 0;
      d  = 4'($urandom_range(0, 15));
      s  = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
      drive_cycle(rn, we, d, s, {$urandom, $urandom}, 1'b1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file: 16 entries x 64 bits.
- Two combinational read ports, addressed by dst and src.
- One synchronous write port that shares the dst address.
- Feeds operands to the datapath/ALU; the result is written back into the register selected by dst.

Parameters:
- DATA_W, 64, width of each register and of every data port.
- ADDR_W, 4, address width; number of entries = 2**ADDR_W (16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk edge.
- writeEnable  input  1  when 1, write dstWrite into entry dst on rising edge.
- dst  input  ADDR_W  destination address; used as write address and as read address for dstRead.
- src  input  ADDR_W  source address for srcRead.
- dstWrite  input  DATA_W  write data.
- dstRead  output  DATA_W  contents of entry dst.
- srcRead  output  DATA_W  contents of entry src.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits. All entries are writable; entry 0 is NOT hardwired to zero.
- Reset:
  - On a rising edge with rst_n=0, every entry clears to 0.
  - Reset has priority over writeEnable; no write occurs in that cycle.
  - Outputs therefore read 0 for any address after reset.
  - Reset asserted mid-sequence discards all prior contents on that edge.
- Write:
  - On a rising edge with rst_n=1 and writeEnable=1, entry[dst] <= dstWrite.
  - Exactly one entry is updated per cycle.
  - With writeEnable=0, no entry changes.
- Read:
  - Purely combinational: dstRead = entry[dst], srcRead = entry[src].
  - No read latency; outputs follow address changes within the same cycle.
  - Written data is visible on the read ports from the cycle after the write edge, i.e. immediately after the edge settles.
- Same-address read and write in the same cycle (macro absent):
  - Reads return the old value until the edge.
  - After the edge, they return the new value.
- dst == src: both read ports return the same entry value.
- Address range: all 2**ADDR_W addresses are valid; there is no out-of-range condition.
- No X propagation: outputs are defined from the first reset onward.
- Unknown or X inputs are not required to be handled.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined, write-through bypass is enabled:
  - If writeEnable=1 and rst_n=1 and src==dst, srcRead = dstWrite combinationally in the same cycle.
  - Likewise dstRead = dstWrite when writeEnable=1 and rst_n=1.
  - Storage update timing is unchanged.
- When not defined: reads always return stored contents only, with the old value during a write cycle, as specified above.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for one edge, then release; sweep dst/src over 0..15.
  - Required: dstRead=srcRead=0 for all addresses.
- Write/readback sweep:
  - Stimulus: for N=0..15, alternate cycles. Write cycle: writeEnable=1, dst=N, dstWrite=pattern[N] (e.g. N=0: 64'h1C8F_BCBF_B54D_70F0). Read cycle: writeEnable=0, dst=src=N.
  - Required: dstRead=srcRead=pattern[N].
- Write disabled:
  - Stimulus: writeEnable=0, dst=3, dstWrite=64'hFFFF_FFFF_FFFF_FFFF for one edge.
  - Required: entry 3 keeps its prior value.
- Independent ports:
  - Stimulus: after writing entry 5 = 64'hA5A5 and entry 10 = 64'h5A5A, set dst=5, src=10.
  - Required: dstRead=64'hA5A5, srcRead=64'h5A5A; address changes reflect with no clock edge.
- Same-cycle write/read:
  - Stimulus: entry 7 = 64'h1; then writeEnable=1, dst=src=7, dstWrite=64'h2.
  - Required before the edge: srcRead=64'h1 (macro absent) or 64'h2 (REGFILE_BYPASS_EN defined).
  - Required after the edge: 64'h2 in both builds.
- Reset priority:
  - Stimulus: rst_n=0 and writeEnable=1, dst=2, dstWrite=64'hDEAD on the same edge.
  - Required: entry 2 = 0 afterwards.
